// File: rtl/qdiv_seq.sv
// Two's-complement front end for the sign-magnitude serial divider: converts operands,
// sequences the divider's start/complete handshake and converts the quotient back.
// Optional feature macro: QDIV_SEQ_DIVZERO_EN (short-circuits zero divisors).
module qdiv_seq #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_op_valid,
  output logic         o_op_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  output logic         o_div_start,
  input  logic [N-1:0] i_div_quotient,
  input  logic         i_div_complete,
  input  logic         i_div_overflow,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [N-1:0] o_result,
  output logic         o_overflow,
  output logic         o_divzero
);

  typedef enum logic [2:0] {
    StSync,
    StIdle,
    StIssue,
    StWaitLo,
    StWaitHi,
    StOut
  } state_e;

  localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] One    = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] dvd_q, dvs_q, result_q;
  logic         sat_q, ovf_q;

  // The most negative value has no positive counterpart; clamp its magnitude to all-ones.
  function automatic logic [N-2:0] to_mag(input logic [N-1:0] x);
    logic [N-1:0] neg;
    neg = ~x + One;
    if (x == MinVal)  to_mag = '1;
    else if (x[N-1])  to_mag = neg[N-2:0];
    else              to_mag = x[N-2:0];
  endfunction

  logic [N-2:0] dvd_mag, dvs_mag, q_mag;
  logic [N-1:0] res_conv;
  logic         accept;

  always_comb begin
    dvd_mag  = to_mag(i_dividend);
    dvs_mag  = to_mag(i_divisor);
    q_mag    = i_div_quotient[N-2:0];
    res_conv = {1'b0, q_mag};
    if (i_div_quotient[N-1] && (q_mag != '0)) res_conv = ~{1'b0, q_mag} + One;
    accept   = (state_q == StIdle) && i_op_valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSync:   if (i_div_complete) state_d = StIdle;
      StIdle: begin
        if (i_op_valid) begin
          state_d = StIssue;
`ifdef QDIV_SEQ_DIVZERO_EN
          if (dvs_mag == '0) state_d = StOut;
`endif
        end
      end
      StIssue:  state_d = StWaitLo;
      StWaitLo: if (!i_div_complete) state_d = StWaitHi;
      StWaitHi: if (i_div_complete) state_d = StOut;
      StOut:    if (i_res_ready) state_d = StIdle;
      default:  state_d = StSync;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StSync;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        dvd_q <= {i_dividend[N-1], dvd_mag};
        dvs_q <= {i_divisor[N-1], dvs_mag};
        sat_q <= (i_dividend == MinVal) || (i_divisor == MinVal);
`ifdef QDIV_SEQ_DIVZERO_EN
        if (dvs_mag == '0) begin
          result_q <= (i_dividend[N-1] ^ i_divisor[N-1]) ? (MinVal + One)
                                                          : {1'b0, {(N-1){1'b1}}};
          ovf_q    <= 1'b1;
        end
`endif
      end
      if ((state_q == StWaitHi) && i_div_complete) begin
        result_q <= res_conv;
        ovf_q    <= sat_q | i_div_overflow;
      end
    end
  end

`ifdef QDIV_SEQ_DIVZERO_EN
  logic dz_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    dz_q <= 1'b0;
    else if (accept) dz_q <= (dvs_mag == '0);
  end
  assign o_divzero = dz_q;
`else
  assign o_divzero = 1'b0;
`endif

  assign o_op_ready     = (state_q == StIdle);
  assign o_div_start    = (state_q == StIssue);
  assign o_res_valid    = (state_q == StOut);
  assign o_div_dividend = dvd_q;
  assign o_div_divisor  = dvs_q;
  assign o_result       = result_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq with a behavioural sign-magnitude serial divider alongside.
module tb_qdiv_seq;
  localparam int Q = 15;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0, op_ready;
  logic [N-1:0]  dividend = '0, divisor = '0;
  logic [N-1:0]  div_dividend, div_divisor, div_quotient;
  logic          div_start, div_complete, div_overflow;
  logic          res_valid, res_ready = 1'b0;
  logic [N-1:0]  result;
  logic          overflow, divzero;

  int checks = 0;
  int failures = 0;
  int starts = 0;

  always #5 clk = ~clk;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_op_valid     (op_valid),
    .o_op_ready     (op_ready),
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .o_div_dividend (div_dividend),
    .o_div_divisor  (div_divisor),
    .o_div_start    (div_start),
    .i_div_quotient (div_quotient),
    .i_div_complete (div_complete),
    .i_div_overflow (div_overflow),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_result       (result),
    .o_overflow     (overflow),
    .o_divzero      (divzero)
  );

  // Divider model: no reset, N+Q-1 iterations after a start pulse.
  logic        m_complete = 1'b1;
  logic [N-1:0] m_quot = '0, m_pend_q = '0;
  logic        m_ovf = 1'b0, m_pend_o = 1'b0;
  int          m_cnt = 0;
  assign div_complete = m_complete;
  assign div_quotient = m_quot;
  assign div_overflow = m_ovf;

  always @(posedge clk) begin
    if (div_start) begin
      logic [63:0] num, qq;
      num = {18'b0, div_dividend[N-2:0], 15'b0};
      qq  = (div_divisor[N-2:0] == '0) ? '1 : num / {33'b0, div_divisor[N-2:0]};
      m_pend_q   <= {div_dividend[N-1] ^ div_divisor[N-1], qq[N-2:0]};
      m_pend_o   <= |qq[63:N-1];
      m_complete <= 1'b0;
      m_cnt      <= N + Q - 1;
      starts     <= starts + 1;
    end else if (!m_complete) begin
      if (m_cnt == 1) begin
        m_complete <= 1'b1;
        m_quot     <= m_pend_q;
        m_ovf      <= m_pend_o;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!op_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, {31'b0, op_ready}, 32'd1);
    op_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    op_valid = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h12345678;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    check({tag, "_vld"}, {31'b0, res_valid}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ovf, output logic dz,
                        output int nstart, output logic [31:0] da, output logic [31:0] db);
    int s0;
    s0 = starts;
    send_op(tag, a, b);
    repeat (3) @(negedge clk);
    da = div_dividend; db = div_divisor;
    wait_res(tag);
    res = result; ovf = overflow; dz = divzero; nstart = starts - s0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [31:0] r, da, db, held;
  logic        ov, dz;
  int          ns, s0, n;

  initial begin
    #12;
    check("rst_rdy", {31'b0, op_ready}, 0);
    check("rst_start", {31'b0, div_start}, 0);
    check("rst_vld", {31'b0, res_valid}, 0);
    check("rst_res", result, 0);
    check("rst_flags", {30'b0, overflow, divzero}, 0);
    check("rst_dvd", div_dividend, 0);
    check("rst_dvs", div_divisor, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("sync_idle", {31'b0, op_ready}, 1);

    run_op("p3d2", 32'h00018000, 32'h00010000, r, ov, dz, ns, da, db);
    check("p3d2_res", r, 32'h0000C000);
    check("p3d2_ovf", {31'b0, ov}, 0);
    check("p3d2_st", ns, 1);
    check("p3d2_da", da, 32'h00018000);
    check("p3d2_db", db, 32'h00010000);

    run_op("n3d2", 32'hFFFE8000, 32'h00010000, r, ov, dz, ns, da, db);
    check("n3d2_res", r, 32'hFFFF4000);
    check("n3d2_da", da, 32'h80018000);

    run_op("zneg", 32'h00000000, 32'hFFFF8000, r, ov, dz, ns, da, db);
    check("zneg_res", r, 32'h00000000);
    check("zneg_db", db, 32'h80008000);

    run_op("sat", 32'h80000000, 32'h00008000, r, ov, dz, ns, da, db);
    check("sat_da_mag", {1'b0, da[30:0]}, 32'h7FFFFFFF);
    check("sat_da_sgn", {31'b0, da[31]}, 1);
    check("sat_ovf", {31'b0, ov}, 1);
    check("sat_res", r, 32'h80000001);

    run_op("dovf", 32'h01000000, 32'h00000100, r, ov, dz, ns, da, db);
    check("dovf_ovf", {31'b0, ov}, 1);

    run_op("clr", 32'h00008000, 32'h00008000, r, ov, dz, ns, da, db);
    check("clr_res", r, 32'h00008000);
    check("clr_ovf", {31'b0, ov}, 0);

    // Backpressure on the result side.
    s0 = starts;
    send_op("hold", 32'h00010000, 32'h00008000);
    wait_res("hold");
    held = result;
    check("hold_res0", held, 32'h00010000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_res", result, held);
      check("hold_vld", {31'b0, res_valid}, 1);
      check("hold_rdy", {31'b0, op_ready}, 0);
    end
    check("hold_st", starts - s0, 1);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    check("hold_idle", {31'b0, op_ready}, 1);

    // Reset with a divide in flight; the stale result must be discarded.
    send_op("rwh", 32'h00018000, 32'h00008000);
    repeat (10) @(negedge clk);
    check("rwh_busy", {31'b0, div_complete}, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rwh_rst_vld", {31'b0, res_valid}, 0);
    rst_n = 1'b1;
    n = 0;
    while (!div_complete && n < 200) begin
      @(negedge clk); n++;
      check("rwh_sync_rdy", {31'b0, op_ready | res_valid}, 0);
    end
    check("rwh_done", {31'b0, div_complete}, 1);
    repeat (2) @(negedge clk);
    check("rwh_idle", {31'b0, op_ready}, 1);
    run_op("rwh_1d1", 32'h00008000, 32'h00008000, r, ov, dz, ns, da, db);
    check("rwh_1d1_res", r, 32'h00008000);
    check("rwh_1d1_st", ns, 1);

`ifdef QDIV_SEQ_DIVZERO_EN
    run_op("dz", 32'h00008000, 32'h00000000, r, ov, dz, ns, da, db);
    check("dz_res", r, 32'h7FFFFFFF);
    check("dz_flag", {31'b0, dz}, 1);
    check("dz_ovf", {31'b0, ov}, 1);
    check("dz_st", ns, 0);
    run_op("dzn", 32'hFFFF8000, 32'h00000000, r, ov, dz, ns, da, db);
    check("dzn_res", r, 32'h80000001);
`else
    run_op("dz", 32'h00008000, 32'h00000000, r, ov, dz, ns, da, db);
    check("dz_flag", {31'b0, dz}, 0);
    check("dz_st", ns, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
